// File: rtl/sar_logic_if.sv
// Handshake and data bundle between a SAR controller (slave) and its driver/analog front end (master).
// The abort signal exists only when SAR_ABORT_EN is defined.
interface sar_logic_if #(
    parameter int N_BITS = 8
);
    logic              start;
    logic              comp_in;
`ifdef SAR_ABORT_EN
    logic              abort;
`endif
    logic [N_BITS-1:0] dac_code;
    logic [N_BITS-1:0] result;
    logic              ready;
    logic              sample_en;
    logic              reg_clk_en;
    logic              busy;

`ifdef SAR_ABORT_EN
    modport master (
        output start, comp_in, abort,
        input  dac_code, result, ready, sample_en, reg_clk_en, busy
    );
    modport slave (
        input  start, comp_in, abort,
        output dac_code, result, ready, sample_en, reg_clk_en, busy
    );
`else
    modport master (
        output start, comp_in,
        input  dac_code, result, ready, sample_en, reg_clk_en, busy
    );
    modport slave (
        input  start, comp_in,
        output dac_code, result, ready, sample_en, reg_clk_en, busy
    );
`endif
endinterface

// File: rtl/sar_logic.sv
// Successive-approximation register controller: IDLE -> SAMPLE -> CONVERT (N_BITS cycles) -> DONE.
// Define SAR_ABORT_EN to add the abort input that cancels a conversion in SAMPLE or CONVERT.
module sar_logic #(
    parameter int N_BITS = 8
) (
    input logic         clk,
    input logic         reset_n,
    sar_logic_if.slave  bus
);
    localparam int KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SAMPLE  = 2'd1;
    localparam logic [1:0] CONVERT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]        state_reg, state_next;
    logic [KW-1:0]     k_reg, k_next;
    logic [N_BITS-1:0] dac_reg, dac_next;
    logic [N_BITS-1:0] result_reg, result_next;
    logic              ready_reg, sample_en_reg, reg_clk_en_reg, busy_reg;

    always_comb begin
        state_next  = state_reg;
        k_next      = k_reg;
        dac_next    = dac_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                state_next               = CONVERT;
                dac_next                 = '0;
                dac_next[N_BITS-1]       = 1'b1;
                k_next                   = KW'(N_BITS - 1);
            end
            CONVERT: begin
                // Decide the current trial bit, then either arm the next lower bit or finish.
                dac_next[k_reg] = bus.comp_in;
                if (k_reg != '0) begin
                    dac_next[k_reg - 1'b1] = 1'b1;
                    k_next                 = k_reg - 1'b1;
                end else begin
                    result_next = dac_next;
                    state_next  = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef SAR_ABORT_EN
        if (bus.abort && (state_reg == SAMPLE || state_reg == CONVERT)) begin
            state_next  = IDLE;
            k_next      = '0;
            dac_next    = '0;
            result_next = result_reg;
        end
`endif
    end

    // Status outputs are registered from the next state so they stay aligned with state_reg.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            k_reg          <= '0;
            dac_reg        <= '0;
            result_reg     <= '0;
            ready_reg      <= 1'b0;
            sample_en_reg  <= 1'b0;
            reg_clk_en_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            k_reg          <= k_next;
            dac_reg        <= dac_next;
            result_reg     <= result_next;
            ready_reg      <= (state_next == DONE);
            sample_en_reg  <= (state_next == SAMPLE);
            reg_clk_en_reg <= (state_next == SAMPLE) || (state_next == CONVERT);
            busy_reg       <= (state_next != IDLE);
        end
    end

    assign bus.dac_code   = dac_reg;
    assign bus.result     = result_reg;
    assign bus.ready      = ready_reg;
    assign bus.sample_en  = sample_en_reg;
    assign bus.reg_clk_en = reg_clk_en_reg;
    assign bus.busy       = busy_reg;
endmodule
